approximate_multiplier_sequencer: RTL and testbench
===================================================

// Module: approximate_multiplier_sequencer
// PURPOSE
//  Front/back-end controller for the 8x8 approximate accuracy-controllable multiplier.
//  Accepts a 32-bit RV32M multiply (MUL/MULH/MULHSU/MULHU).
//  Feeds 16 byte-slice partial products serially into the external multiplier instance.
//  Accumulates the returned 16-bit products, applies the sign and returns the selected 32-bit half.
//  Sits between the execute-stage dispatch and the approximate multiplier.
// PARAMETERS
//  XLEN         32  operand/result width
//  SLICE        8   multiplier operand width (XLEN/SLICE = 4 slices per operand)
//  MUL_LATENCY  2   cycles from mul_multiplicand/mul_multiplier valid to matching mul_product
// PORTS
//  CLK               in   1      clock, rising edge
//  reset             in   1      synchronous, active-high
//  start_valid       in   1      request valid
//  start_ready       out  1      high only in IDLE
//  funct3            in   3      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; others treated as MULHU
//  operand_1         in   XLEN   rs1
//  operand_2         in   XLEN   rs2
//  accuracy_control  in   7      Er value, latched at accept, driven unchanged on mul_er
//  mul_multiplicand  out  SLICE  byte of |operand_1| to multiplier
//  mul_multiplier    out  SLICE  byte of |operand_2| to multiplier
//  mul_er            out  7      latched Er
//  mul_product       in   2*SLICE  product returned MUL_LATENCY cycles after issue
//  result_valid      out  1      one-cycle pulse
//  result            out  XLEN   held stable from the result_valid pulse until the next accept
//  busy              out  1      ~start_ready
// BEHAVIOUR
//  Reset values:
//   - state IDLE; start_ready=1; busy=0; result_valid=0; result=0.
//   - mul_* = 0; accumulator and tag delay line cleared.
//  Reset mid-operation discards the operation; no result_valid.
//  Accept on rising edge with start_valid&&start_ready. At accept, latch:
//   - funct3 and Er.
//   - |op1| and |op2| (signed per funct3; abs(0x80000000)=0x80000000 unsigned).
//   - neg = sign1^sign2.
//   - MUL treats both operands as signed; low word is sign-agnostic.
//  States:
//   - IDLE -> ISSUE on accept.
//   - ISSUE: one slice pair per cycle. k=0..15, i=k[3:2] (op1 byte), j=k[1:0] (op2 byte).
//     Drive bytes on mul_*. Push tag {valid=1, shift=8*(i+j)} into MUL_LATENCY-deep delay line.
//     ISSUE -> DRAIN after last issue.
//   - DRAIN: mul_*=0, push valid=0 tags. DRAIN -> DONE when the delay line holds no valid tag.
//   - DONE: 64-bit acc negated if neg. result = MUL ? acc[31:0] : acc[63:32].
//     result_valid=1 for exactly this cycle. DONE -> IDLE.
//  Accumulate: each edge with delay-line output valid: acc += {48'b0,mul_product} << shift (64-bit, wraps).
//  Latency: result_valid high max(N,1)+MUL_LATENCY+1 cycles after the accept edge.
//   - N = issued pairs; N=16 without the option.
//  start_valid while busy is ignored (no queueing). Back-to-back ops: next accept in the cycle after DONE.
// CONFIGURATION
//  MUL_ZERO_SKIP_EN defined:
//   - 16-bit nonzero-pair mask computed at accept; ISSUE visits only set bits, ascending k.
//   - N=popcount(mask). If N=0, ISSUE lasts one cycle with no valid issue, result 0.
//  MUL_ZERO_SKIP_EN undefined: all 16 pairs issued, fixed latency 17+MUL_LATENCY.
// STRUCTURE
//  Shared header: funct3 encodings, state encodings, SLICE/XLEN defaults.
//  Sub-module mul_tag_delay_line: MUL_LATENCY-stage shift register of {valid, shift[5:0]}.
//   - Synchronous clear on reset.
//  Accumulator, sign logic and FSM live in the top.
// TESTING (bench model: exact multiplier with MUL_LATENCY register stages; Er=7'h7F)
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE, result_valid exactly 17+MUL_LATENCY cycles after accept.
//  MUL 0x00000007 x 0xFFFFFFFD -> result 0xFFFFFFEB.
//   - start_valid held high during busy is not accepted twice.
//  MULH 0x80000000 x 0x80000000 -> result 0x40000000.
//  MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFF.
//   - MULHU of the same operands -> 0xFFFFFFFE.
//  Reset asserted 5 cycles into ISSUE -> no result_valid, start_ready=1 after reset.
//   - Then MUL 3 x 4 -> 12.
//  MUL_ZERO_SKIP_EN: MUL 5 x 3 -> 15 at 2+MUL_LATENCY cycles; MUL 0 x 0x1234 -> 0 at 2+MUL_LATENCY.

Source files
------------

// File: rtl/approximate_multiplier_sequencer_pkg.sv
// Shared types for the approximate multiplier sequencer: widths, funct3 and state encodings, delay-line tag.
// Optional zero-pair skipping is selected with MUL_ZERO_SKIP_EN.
package approximate_multiplier_sequencer_pkg;

    localparam int XLEN        = 32;
    localparam int SLICE       = 8;
    localparam int MUL_LATENCY = 2;
    localparam int NPAIR       = (XLEN / SLICE) * (XLEN / SLICE);

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [5:0] shift;
    } tag_t;

    // Returns {found, index} of the lowest set bit of a 16-bit pair mask.
    function automatic logic [4:0] first_set(input logic [15:0] mask);
        logic [4:0] pick;
        pick = '0;
        for (int k = 15; k >= 0; k--) begin
            if (mask[k]) pick = {1'b1, 4'(k)};
        end
        return pick;
    endfunction

endpackage

// File: rtl/approximate_multiplier_sequencer_if.sv
// Dispatch-side request/result handshake and external 8x8 multiplier bus.
// master = dispatch and multiplier environment, slave = sequencer.
interface approximate_multiplier_sequencer_if;
    import approximate_multiplier_sequencer_pkg::*;

    logic                 start_valid;
    logic                 start_ready;
    logic [2:0]           funct3;
    logic [XLEN-1:0]      operand_1;
    logic [XLEN-1:0]      operand_2;
    logic [6:0]           accuracy_control;
    logic [SLICE-1:0]     mul_multiplicand;
    logic [SLICE-1:0]     mul_multiplier;
    logic [6:0]           mul_er;
    logic [2*SLICE-1:0]   mul_product;
    logic                 result_valid;
    logic [XLEN-1:0]      result;
    logic                 busy;

    modport master (
        output start_valid, funct3, operand_1, operand_2, accuracy_control, mul_product,
        input  start_ready, mul_multiplicand, mul_multiplier, mul_er, result_valid, result, busy
    );

    modport slave (
        input  start_valid, funct3, operand_1, operand_2, accuracy_control, mul_product,
        output start_ready, mul_multiplicand, mul_multiplier, mul_er, result_valid, result, busy
    );
endinterface

// File: rtl/approximate_multiplier_sequencer_tag_delay_line.sv
// Tag shift register matching the external multiplier latency; output tag pairs with mul_product.
// Fixed latency DEPTH cycles, no backpressure; pending flags any valid tag still in flight.
module mul_tag_delay_line
    import approximate_multiplier_sequencer_pkg::*;
#(
    parameter int DEPTH = MUL_LATENCY
) (
    input  logic clk,
    input  logic reset,
    input  tag_t push_tag,
    output tag_t pop_tag,
    output logic pending
);
    tag_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < DEPTH; d++) stage_q[d] <= '0;
        end else begin
            stage_q[0] <= push_tag;
            for (int d = 1; d < DEPTH; d++) stage_q[d] <= stage_q[d-1];
        end
    end

    assign pop_tag = stage_q[DEPTH-1];

    always_comb begin
        pending = 1'b0;
        for (int d = 0; d < DEPTH; d++) pending = pending | stage_q[d].valid;
    end
endmodule

// File: rtl/approximate_multiplier_sequencer.sv
// RV32M multiply sequencer: splits |op1| x |op2| into byte pairs for an external 8x8 multiplier, accumulates, re-signs.
// Latency max(N,1)+MUL_LATENCY+1 cycles (N=16 unless MUL_ZERO_SKIP_EN skips zero pairs); no queueing, start_ready only in IDLE.
module approximate_multiplier_sequencer
    import approximate_multiplier_sequencer_pkg::*;
(
    input  logic                              CLK,
    input  logic                              reset,
    approximate_multiplier_sequencer_if.slave bus
);
    localparam int DCW = $clog2(MUL_LATENCY + 1);

    state_e             state_q, state_d;
    logic [2:0]         f3_q;
    logic [6:0]         er_q;
    logic [XLEN-1:0]    a_q, b_q;
    logic               neg_q;
    logic [NPAIR-1:0]   mask_q, mask_d, mask_init;
    logic [2*XLEN-1:0]  acc_q, acc_signed;
    logic [XLEN-1:0]    result_q;
    logic [DCW-1:0]     drain_cnt_q;
    logic               accept, sign1, sign2;
    logic [XLEN-1:0]    abs1, abs2;
    logic [4:0]         pick;
    logic [1:0]         pi, pj;
    tag_t               push_tag, pop_tag;
    logic               pending;

    assign accept = bus.start_valid && (state_q == S_IDLE);

    always_comb begin
        sign1 = (bus.funct3 == F3_MUL || bus.funct3 == F3_MULH || bus.funct3 == F3_MULHSU) && bus.operand_1[XLEN-1];
        sign2 = (bus.funct3 == F3_MUL || bus.funct3 == F3_MULH) && bus.operand_2[XLEN-1];
        abs1  = sign1 ? -bus.operand_1 : bus.operand_1;
        abs2  = sign2 ? -bus.operand_2 : bus.operand_2;
`ifdef MUL_ZERO_SKIP_EN
        mask_init = '0;
        for (int i = 0; i < XLEN / SLICE; i++) begin
            for (int j = 0; j < XLEN / SLICE; j++) begin
                mask_init[i*(XLEN/SLICE)+j] = (|abs1[i*SLICE +: SLICE]) && (|abs2[j*SLICE +: SLICE]);
            end
        end
`else
        mask_init = '1;
`endif
    end

    always_comb begin
        state_d              = state_q;
        mask_d               = mask_q;
        push_tag             = '0;
        bus.mul_multiplicand = '0;
        bus.mul_multiplier   = '0;
        pick                 = first_set(mask_q);
        pi                   = pick[3:2];
        pj                   = pick[1:0];
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_ISSUE;
            S_ISSUE: begin
                if (pick[4]) begin
                    bus.mul_multiplicand = a_q[{pi, 3'b000} +: SLICE];
                    bus.mul_multiplier   = b_q[{pj, 3'b000} +: SLICE];
                    push_tag.valid       = 1'b1;
                    push_tag.shift       = {({1'b0, pi} + {1'b0, pj}), 3'b000};
                    mask_d[pick[3:0]]    = 1'b0;
                end
                if (mask_d == '0) state_d = S_DRAIN;
            end
            // An empty ISSUE still waits a full drain so latency stays max(N,1)+MUL_LATENCY+1.
            S_DRAIN: if (!pending && drain_cnt_q >= DCW'(MUL_LATENCY)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    mul_tag_delay_line #(.DEPTH(MUL_LATENCY)) u_tag_line (
        .clk      (CLK),
        .reset    (reset),
        .push_tag (push_tag),
        .pop_tag  (pop_tag),
        .pending  (pending)
    );

    assign acc_signed = neg_q ? -acc_q : acc_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            f3_q        <= '0;
            er_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            mask_q      <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            drain_cnt_q <= (state_q == S_DRAIN && drain_cnt_q < DCW'(MUL_LATENCY)) ? drain_cnt_q + 1'b1
                         : (state_q == S_DRAIN) ? drain_cnt_q : '0;
            if (accept) begin
                f3_q   <= bus.funct3;
                er_q   <= bus.accuracy_control;
                a_q    <= abs1;
                b_q    <= abs2;
                neg_q  <= sign1 ^ sign2;
                mask_q <= mask_init;
                acc_q  <= '0;
            end else if (pop_tag.valid) begin
                acc_q <= acc_q + ({{(2*XLEN-2*SLICE){1'b0}}, bus.mul_product} << pop_tag.shift);
            end
            if (state_q == S_DRAIN && state_d == S_DONE) begin
                result_q <= (f3_q == F3_MUL) ? acc_signed[XLEN-1:0] : acc_signed[2*XLEN-1:XLEN];
            end
        end
    end

    assign bus.start_ready  = (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.result       = result_q;
    assign bus.mul_er       = er_q;
endmodule

// File: tb/tb_approximate_multiplier_sequencer.sv
// Directed bench for approximate_multiplier_sequencer with an exact 8x8 multiplier model of MUL_LATENCY stages.
// Build with MUL_ZERO_SKIP_EN to exercise zero-pair skipping.
module tb_approximate_multiplier_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [15:0] p1, p2;

`ifdef MUL_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    approximate_multiplier_sequencer_if bus ();

    approximate_multiplier_sequencer dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1 <= 16'(bus.mul_multiplicand) * 16'(bus.mul_multiplier);
        p2 <= p1;
    end
    assign bus.mul_product = p2;

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        int n;
        x = ((f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) && a[31]) ? -a : a;
        y = ((f3 == 3'b000 || f3 == 3'b001) && b[31]) ? -b : b;
        n = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (!SKIP || (x[8*i +: 8] != 8'h00 && y[8*j +: 8] != 8'h00)) n++;
        return ((n == 0) ? 1 : n) + 3;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the result pulse.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit hold,
                         output int lat, output logic [31:0] res, output logic rv_after,
                         output logic [31:0] res_after, output logic [7:0] b1, output logic [7:0] b2,
                         output logic [6:0] er, output logic busy_after);
        bus.start_valid      = 1'b1;
        bus.funct3           = f3;
        bus.operand_1        = a;
        bus.operand_2        = b;
        bus.accuracy_control = 7'h7F;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.start_valid = 1'b0;
        bus.accuracy_control = 7'h00;
        b1  = bus.mul_multiplicand;
        b2  = bus.mul_multiplier;
        er  = bus.mul_er;
        lat = 0;
        while (bus.result_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = bus.result;
        bus.start_valid = 1'b0;
        @(negedge clk);
        rv_after   = bus.result_valid;
        res_after  = bus.result;
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.start_ready !== 1'b1) begin failures++; $display("FAIL reset_start_ready got=%b want=1", bus.start_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL reset_result_valid got=%b want=0", bus.result_valid); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=0", bus.result); end
        checks++; if (bus.mul_multiplicand !== 8'h0 || bus.mul_multiplier !== 8'h0) begin
            failures++; $display("FAIL reset_mul_bytes got=%h/%h want=00/00", bus.mul_multiplicand, bus.mul_multiplier); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mulhu_max();
        int lat; logic [31:0] res, res2; logic rv2, bz; logic [7:0] b1, b2; logic [6:0] er;
        do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, res, rv2, res2, b1, b2, er, bz);
        checks++; if (lat !== exp_lat(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF)) begin failures++; $display("FAIL mulhu_latency got=%0d want=%0d", lat, exp_lat(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF)); end
        checks++; if (res !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu_result got=%h want=fffffffe", res); end
        checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL mulhu_pulse_width got=%b want=0", rv2); end
        checks++; if (res2 !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu_result_hold got=%h want=fffffffe", res2); end
        checks++; if (er !== 7'h7F) begin failures++; $display("FAIL mulhu_er got=%h want=7f", er); end
        checks++; if (b1 !== 8'hFF || b2 !== 8'hFF) begin failures++; $display("FAIL mulhu_first_bytes got=%h/%h want=ff/ff", b1, b2); end
    endtask

    task automatic test_mul_hold_valid();
        int lat; logic [31:0] res, res2; logic rv2, bz; logic [7:0] b1, b2; logic [6:0] er;
        do_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 1'b1, lat, res, rv2, res2, b1, b2, er, bz);
        checks++; if (res !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result got=%h want=ffffffeb", res); end
        checks++; if (lat !== exp_lat(3'b000, 32'h7, 32'hFFFFFFFD)) begin failures++; $display("FAIL mul_latency got=%0d want=%0d", lat, exp_lat(3'b000, 32'h7, 32'hFFFFFFFD)); end
        checks++; if (b1 !== 8'h07 || b2 !== 8'h03) begin failures++; $display("FAIL mul_first_bytes got=%h/%h want=07/03", b1, b2); end
        checks++; if (bz !== 1'b0) begin failures++; $display("FAIL mul_no_reaccept_busy got=%b want=0", bz); end
    endtask

    task automatic test_mulh_min();
        int lat; logic [31:0] res, res2; logic rv2, bz; logic [7:0] b1, b2; logic [6:0] er;
        do_op(3'b001, 32'h80000000, 32'h80000000, 1'b0, lat, res, rv2, res2, b1, b2, er, bz);
        checks++; if (res !== 32'h40000000) begin failures++; $display("FAIL mulh_result got=%h want=40000000", res); end
        checks++; if (lat !== exp_lat(3'b001, 32'h80000000, 32'h80000000)) begin failures++; $display("FAIL mulh_latency got=%0d want=%0d", lat, exp_lat(3'b001, 32'h80000000, 32'h80000000)); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res, res2; logic rv2, bz; logic [7:0] b1, b2; logic [6:0] er;
        do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, res, rv2, res2, b1, b2, er, bz);
        checks++; if (res !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu_result got=%h want=ffffffff", res); end
        checks++; if (bus.start_ready !== 1'b1) begin failures++; $display("FAIL b2b_start_ready got=%b want=1", bus.start_ready); end
        do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, res, rv2, res2, b1, b2, er, bz);
        checks++; if (res !== 32'hFFFFFFFE) begin failures++; $display("FAIL b2b_mulhu_result got=%h want=fffffffe", res); end
        checks++; if (lat !== exp_lat(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF)) begin failures++; $display("FAIL b2b_latency got=%0d want=%0d", lat, exp_lat(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF)); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [31:0] res, res2; logic rv2, bz, seen; logic [7:0] b1, b2; logic [6:0] er;
        bus.start_valid = 1'b1;
        bus.funct3      = 3'b011;
        bus.operand_1   = 32'hFFFFFFFF;
        bus.operand_2   = 32'hFFFFFFFF;
        bus.accuracy_control = 7'h7F;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.start_ready !== 1'b1) begin failures++; $display("FAIL midreset_start_ready got=%b want=1", bus.start_ready); end
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.result_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_result got=%b want=0", seen); end
        do_op(3'b000, 32'd3, 32'd4, 1'b0, lat, res, rv2, res2, b1, b2, er, bz);
        checks++; if (res !== 32'd12) begin failures++; $display("FAIL midreset_mul_result got=%h want=0000000c", res); end
        checks++; if (lat !== exp_lat(3'b000, 32'd3, 32'd4)) begin failures++; $display("FAIL midreset_mul_latency got=%0d want=%0d", lat, exp_lat(3'b000, 32'd3, 32'd4)); end
    endtask

`ifdef MUL_ZERO_SKIP_EN
    task automatic test_zero_skip();
        int lat; logic [31:0] res, res2; logic rv2, bz; logic [7:0] b1, b2; logic [6:0] er;
        do_op(3'b000, 32'd5, 32'd3, 1'b0, lat, res, rv2, res2, b1, b2, er, bz);
        checks++; if (res !== 32'd15) begin failures++; $display("FAIL skip_mul_result got=%h want=0000000f", res); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL skip_mul_latency got=%0d want=4", lat); end
        do_op(3'b000, 32'd0, 32'h1234, 1'b0, lat, res, rv2, res2, b1, b2, er, bz);
        checks++; if (res !== 32'd0) begin failures++; $display("FAIL skip_zero_result got=%h want=0", res); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL skip_zero_latency got=%0d want=4", lat); end
    endtask
`endif

    initial begin
        checks               = 0;
        failures             = 0;
        reset                = 1'b1;
        bus.start_valid      = 1'b0;
        bus.funct3           = 3'b000;
        bus.operand_1        = '0;
        bus.operand_2        = '0;
        bus.accuracy_control = '0;
        test_reset();
        test_mulhu_max();
        test_mul_hold_valid();
        test_mulh_min();
        test_back_to_back();
        test_reset_mid_op();
`ifdef MUL_ZERO_SKIP_EN
        test_zero_skip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
